// File: rtl/bsg_manycore_vcache_dma_wh_mux_if.sv
// One direction of a ready_and wormhole link: valid/data forward, ready_and backward.
interface bsg_manycore_vcache_dma_wh_mux_if #(
    parameter int width_p = 32
);
    logic               v;
    logic               ready_and;
    logic [width_p-1:0] data;

    modport master (output v, output data, input ready_and);
    modport slave  (input v, input data, output ready_and);
endinterface

// File: rtl/bsg_manycore_vcache_dma_wh_mux.sv
// Multiplexes num_dma_p vcache DMA channels onto one wormhole link with round-robin packet arbitration.
// Optional: define BSG_VCACHE_DMA_WH_OUT_FIFO_EN to insert a 2-entry fifo on the outgoing flit path.
module bsg_manycore_vcache_dma_wh_mux #(
    parameter int num_dma_p             = 2,
    parameter int dma_addr_width_p      = 32,
    parameter int dma_data_width_p      = 32,
    parameter int block_size_in_words_p = 8,
    parameter int wh_flit_width_p       = 32,
    parameter int wh_cord_width_p       = 8,
    parameter int wh_len_width_p        = 4,
    parameter int wh_cid_width_p        = 4
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,

    input  logic [num_dma_p-1:0][dma_addr_width_p:0]      dma_pkt_i,
    input  logic [num_dma_p-1:0]                          dma_pkt_v_i,
    output logic [num_dma_p-1:0]                          dma_pkt_yumi_o,

    output logic [num_dma_p-1:0][dma_data_width_p-1:0]    dma_data_o,
    output logic [num_dma_p-1:0]                          dma_data_v_o,
    input  logic [num_dma_p-1:0]                          dma_data_ready_i,

    input  logic [num_dma_p-1:0][dma_data_width_p-1:0]    dma_data_i,
    input  logic [num_dma_p-1:0]                          dma_data_v_i,
    output logic [num_dma_p-1:0]                          dma_data_yumi_o,

    bsg_manycore_vcache_dma_wh_mux_if.slave               wh_link_sif_i,
    bsg_manycore_vcache_dma_wh_mux_if.master              wh_link_sif_o,

    input  logic [wh_cord_width_p-1:0]                    my_wh_cord_i,
    input  logic [wh_cord_width_p-1:0]                    dest_wh_cord_i,
    input  logic [wh_cid_width_p-1:0]                     my_wh_cid_i,
    output logic                                          cid_error_o
);

    localparam int ch_width_lp  = (num_dma_p > 1) ? $clog2(num_dma_p) : 1;
    localparam int cnt_width_lp = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
    localparam int len_lsb_lp   = wh_cord_width_p;
    localparam int cid_lsb_lp   = wh_cord_width_p + wh_len_width_p;

    typedef struct packed {
        logic [wh_cord_width_p-1:0] src_cord;
        logic                       write_not_read;
        logic [wh_cid_width_p-1:0]  cid;
        logic [wh_len_width_p-1:0]  len;
        logic [wh_cord_width_p-1:0] cord;
    } header_s;

    localparam int header_width_lp = $bits(header_s);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_ADDR, S_DATA} send_state_e;
    typedef enum logic       {R_HDR, R_DATA} recv_state_e;

    function automatic logic [ch_width_lp-1:0] next_ch(input logic [ch_width_lp-1:0] c);
        if (int'(c) == num_dma_p - 1) return '0;
        return c + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Send path
    // ------------------------------------------------------------------
    send_state_e                  send_state_reg, send_state_next;
    logic [ch_width_lp-1:0]       ch_reg, ch_next;
    logic [ch_width_lp-1:0]       ptr_reg, ptr_next;
    logic [cnt_width_lp-1:0]      beat_reg, beat_next;
    logic [ch_width_lp-1:0]       grant_ch;
    logic                         grant_found;
    logic                         cur_wnr;
    header_s                      tx_hdr;
    logic                         send_v;
    logic                         send_ready;
    logic [wh_flit_width_p-1:0]   send_flit;

    // First requester at or after the priority pointer wins.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = ptr_reg;
        for (int i = 0; i < num_dma_p; i++) begin
            if (!grant_found && dma_pkt_v_i[(int'(ptr_reg) + i) % num_dma_p]) begin
                grant_found = 1'b1;
                grant_ch    = ch_width_lp'((int'(ptr_reg) + i) % num_dma_p);
            end
        end
    end

    // The request stays valid until its yumi, so header fields can read it live.
    assign cur_wnr = dma_pkt_i[ch_reg][dma_addr_width_p];

    always_comb begin
        tx_hdr.src_cord       = my_wh_cord_i;
        tx_hdr.write_not_read = cur_wnr;
        tx_hdr.cid            = my_wh_cid_i | wh_cid_width_p'(ch_reg);
        tx_hdr.len            = cur_wnr ? wh_len_width_p'(block_size_in_words_p + 1)
                                        : wh_len_width_p'(1);
        tx_hdr.cord           = dest_wh_cord_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            send_state_reg <= S_IDLE;
            ch_reg         <= '0;
            ptr_reg        <= '0;
            beat_reg       <= '0;
        end else begin
            send_state_reg <= send_state_next;
            ch_reg         <= ch_next;
            ptr_reg        <= ptr_next;
            beat_reg       <= beat_next;
        end
    end

    always_comb begin
        send_state_next = send_state_reg;
        ch_next         = ch_reg;
        ptr_next        = ptr_reg;
        beat_next       = beat_reg;
        send_v          = 1'b0;
        send_flit       = '0;
        dma_pkt_yumi_o  = '0;
        dma_data_yumi_o = '0;

        case (send_state_reg)
            S_IDLE: begin
                if (grant_found) begin
                    ch_next         = grant_ch;
                    send_state_next = S_HDR;
                end
            end
            S_HDR: begin
                send_v                            = 1'b1;
                send_flit[header_width_lp-1:0]    = tx_hdr;
                if (send_ready) send_state_next   = S_ADDR;
            end
            S_ADDR: begin
                send_v                             = 1'b1;
                send_flit[dma_addr_width_p-1:0]    = dma_pkt_i[ch_reg][dma_addr_width_p-1:0];
                if (send_ready) begin
                    dma_pkt_yumi_o[ch_reg] = 1'b1;
                    if (cur_wnr) begin
                        beat_next       = '0;
                        send_state_next = S_DATA;
                    end else begin
                        ptr_next        = next_ch(ch_reg);
                        send_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                send_v                             = dma_data_v_i[ch_reg];
                send_flit[dma_data_width_p-1:0]    = dma_data_i[ch_reg];
                if (send_v && send_ready) begin
                    dma_data_yumi_o[ch_reg] = 1'b1;
                    if (beat_reg == cnt_width_lp'(block_size_in_words_p - 1)) begin
                        ptr_next        = next_ch(ch_reg);
                        send_state_next = S_IDLE;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
            end
            default: send_state_next = S_IDLE;
        endcase
    end

`ifdef BSG_VCACHE_DMA_WH_OUT_FIFO_EN
    // Two entries keep 1 flit/cycle while the enqueue side only sees registered full.
    logic [wh_flit_width_p-1:0] fifo_mem_reg [2];
    logic                       wr_ptr_reg, rd_ptr_reg;
    logic [1:0]                 count_reg;
    logic                       enq, deq;

    assign send_ready = (count_reg != 2'd2);
    assign enq        = send_v & send_ready;
    assign deq        = wh_link_sif_o.v & wh_link_sif_o.ready_and;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (enq) wr_ptr_reg <= ~wr_ptr_reg;
            if (deq) rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, enq} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) fifo_mem_reg[wr_ptr_reg] <= send_flit;
    end

    assign wh_link_sif_o.v    = (count_reg != 2'd0);
    assign wh_link_sif_o.data = fifo_mem_reg[rd_ptr_reg];
`else
    assign send_ready         = wh_link_sif_o.ready_and;
    assign wh_link_sif_o.v    = send_v;
    assign wh_link_sif_o.data = send_flit;
`endif

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    recv_state_e                recv_state_reg, recv_state_next;
    logic [wh_cid_width_p-1:0]  rch_reg, rch_next;
    logic [wh_len_width_p-1:0]  rcount_reg, rcount_next;
    logic                       error_reg, error_next;
    logic [wh_len_width_p-1:0]  rx_len;
    logic [wh_cid_width_p-1:0]  rx_ch;
    logic                       rch_in_range;
    logic                       rx_ready;
    logic [num_dma_p-1:0]       fill_v;

    // Channel is the cid offset from our base; mismatched upper bits land out of range.
    assign rx_len       = wh_link_sif_i.data[len_lsb_lp +: wh_len_width_p];
    assign rx_ch        = wh_link_sif_i.data[cid_lsb_lp +: wh_cid_width_p] ^ my_wh_cid_i;
    assign rch_in_range = (int'(rch_reg) < num_dma_p);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            recv_state_reg <= R_HDR;
            rch_reg        <= '0;
            rcount_reg     <= '0;
            error_reg      <= 1'b0;
        end else begin
            recv_state_reg <= recv_state_next;
            rch_reg        <= rch_next;
            rcount_reg     <= rcount_next;
            error_reg      <= error_next;
        end
    end

    always_comb begin
        recv_state_next = recv_state_reg;
        rch_next        = rch_reg;
        rcount_next     = rcount_reg;
        error_next      = error_reg;
        rx_ready        = 1'b0;
        fill_v          = '0;

        case (recv_state_reg)
            R_HDR: begin
                rx_ready = 1'b1;
                if (wh_link_sif_i.v) begin
                    rch_next    = rx_ch;
                    rcount_next = rx_len;
                    if (int'(rx_ch) >= num_dma_p) error_next = 1'b1;
                    if (rx_len != '0) recv_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (rch_in_range) begin
                    fill_v[rch_reg[ch_width_lp-1:0]] = wh_link_sif_i.v;
                    rx_ready = dma_data_ready_i[rch_reg[ch_width_lp-1:0]];
                end else begin
                    rx_ready = 1'b1;
                end
                if (wh_link_sif_i.v && rx_ready) begin
                    rcount_next = rcount_reg - 1'b1;
                    if (rcount_reg == wh_len_width_p'(1)) recv_state_next = R_HDR;
                end
            end
            default: recv_state_next = R_HDR;
        endcase
    end

    assign wh_link_sif_i.ready_and = rx_ready & reset_n_i;
    assign dma_data_v_o            = fill_v;
    assign cid_error_o             = error_reg;

    for (genvar gi = 0; gi < num_dma_p; gi++) begin : g_fill_data
        assign dma_data_o[gi] = wh_link_sif_i.data[dma_data_width_p-1:0];
    end

endmodule

// File: tb/tb_bsg_manycore_vcache_dma_wh_mux.sv
// Scoreboard bench: stimulus pushes expected flits/fill beats, a negedge monitor pops and compares.
module tb_bsg_manycore_vcache_dma_wh_mux;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0][32:0]  dma_pkt;
    logic [1:0]        dma_pkt_v, dma_pkt_yumi;
    logic [1:0][31:0]  fill_data;
    logic [1:0]        fill_v, fill_ready;
    logic [1:0][31:0]  evict_data;
    logic [1:0]        evict_v, evict_yumi;
    logic [7:0]        my_cord   = 8'h12;
    logic [7:0]        dest_cord = 8'h34;
    logic [3:0]        my_cid    = 4'h4;
    logic              cid_error;

    bsg_manycore_vcache_dma_wh_mux_if #(.width_p(32)) tx_link ();
    bsg_manycore_vcache_dma_wh_mux_if #(.width_p(32)) rx_link ();

    bsg_manycore_vcache_dma_wh_mux dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .dma_pkt_i        (dma_pkt),
        .dma_pkt_v_i      (dma_pkt_v),
        .dma_pkt_yumi_o   (dma_pkt_yumi),
        .dma_data_o       (fill_data),
        .dma_data_v_o     (fill_v),
        .dma_data_ready_i (fill_ready),
        .dma_data_i       (evict_data),
        .dma_data_v_i     (evict_v),
        .dma_data_yumi_o  (evict_yumi),
        .wh_link_sif_i    (rx_link),
        .wh_link_sif_o    (tx_link),
        .my_wh_cord_i     (my_cord),
        .dest_wh_cord_i   (dest_cord),
        .my_wh_cid_i      (my_cid),
        .cid_error_o      (cid_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] tx_exp_q [$];
    logic [31:0] fill_exp_q0 [$];
    logic [31:0] fill_exp_q1 [$];

    int          req_issued [2];
    logic [32:0] req_pkt [2];
    int          pkt_yumi_cnt [2];
    int          evict_total [2];
    int          evict_yumi_cnt [2];
    logic [31:0] evict_mem [2][32];
    bit          fill_toggle = 0;
    bit          tx_toggle = 0;

    // Bus model: inputs change 1 time unit after the rising edge
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < 2; c++) begin
            dma_pkt_v[c]  = (req_issued[c] > pkt_yumi_cnt[c]);
            dma_pkt[c]    = req_pkt[c];
            evict_v[c]    = (evict_yumi_cnt[c] < evict_total[c]);
            evict_data[c] = evict_mem[c][evict_yumi_cnt[c] % 32];
        end
        fill_ready        = fill_toggle ? ~fill_ready : 2'b11;
        tx_link.ready_and = tx_toggle ? ~tx_link.ready_and : 1'b1;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (reset_n === 1'b1) begin
            if (tx_link.v && tx_link.ready_and) begin
                checks++;
                if (tx_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_unexpected actual=0x%08h expected=none", tx_link.data);
                end else begin
                    exp_w = tx_exp_q.pop_front();
                    $display("tx flit actual=0x%08h expected=0x%08h", tx_link.data, exp_w);
                    if (tx_link.data !== exp_w) begin
                        failures++;
                        $display("FAIL tx_flit actual=0x%08h expected=0x%08h", tx_link.data, exp_w);
                    end
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (fill_v[c]) begin
                    if ((c == 0 ? fill_exp_q0.size() : fill_exp_q1.size()) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL fill_spurious ch=%0d actual=0x%08h expected=none", c, fill_data[c]);
                    end else if (fill_ready[c]) begin
                        exp_w = (c == 0) ? fill_exp_q0.pop_front() : fill_exp_q1.pop_front();
                        checks++;
                        $display("fill ch=%0d actual=0x%08h expected=0x%08h", c, fill_data[c], exp_w);
                        if (fill_data[c] !== exp_w) begin
                            failures++;
                            $display("FAIL fill_data ch=%0d actual=0x%08h expected=0x%08h", c, fill_data[c], exp_w);
                        end
                    end
                end
                if (dma_pkt_yumi[c]) pkt_yumi_cnt[c]++;
                if (evict_yumi[c])   evict_yumi_cnt[c]++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        $display("check %s actual=0x%08h expected=0x%08h", name, act, exp);
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic issue_req(input int c, input bit wnr, input logic [31:0] addr);
        req_pkt[c]    = {wnr, addr};
        req_issued[c] = req_issued[c] + 1;
    endtask

    task automatic wait_done(input string name);
        bit done = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (tx_exp_q.size() == 0 &&
                req_issued[0] == pkt_yumi_cnt[0] && req_issued[1] == pkt_yumi_cnt[1] &&
                evict_total[0] == evict_yumi_cnt[0] && evict_total[1] == evict_yumi_cnt[1]) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout actual=pending expected=drained", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_fill(input string name);
        bit done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (fill_exp_q0.size() == 0 && fill_exp_q1.size() == 0) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout actual=pending expected=drained", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic rx_flit(input logic [31:0] d);
        bit taken = 0;
        rx_link.v    = 1'b1;
        rx_link.data = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rx_link.ready_and) begin
                taken = 1;
                break;
            end
        end
        if (!taken) begin
            checks++;
            failures++;
            $display("FAIL rx_accept actual=stalled expected=accepted flit=0x%08h", d);
        end
        @(posedge clk); #1;
        rx_link.v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        rx_link.v    = 1'b0;
        rx_link.data = '0;
        for (int c = 0; c < 2; c++) begin
            req_issued[c] = 0; req_pkt[c] = '0; pkt_yumi_cnt[c] = 0;
            evict_total[c] = 0; evict_yumi_cnt[c] = 0;
            for (int w = 0; w < 32; w++) evict_mem[c][w] = '0;
        end
        for (int w = 0; w < 8; w++) begin
            evict_mem[1][w]     = 32'hA0 + w;
            evict_mem[1][w + 8] = 32'hC0 + w;
        end
        for (int w = 0; w < 4; w++) evict_mem[0][w] = 32'hD0 + w;

        repeat (3) @(posedge clk);
        #2;
        check("rst_tx_v",       32'(tx_link.v), 32'h0);
        check("rst_rx_ready",   32'(rx_link.ready_and), 32'h0);
        check("rst_pkt_yumi",   32'(dma_pkt_yumi), 32'h0);
        check("rst_evict_yumi", 32'(evict_yumi), 32'h0);
        check("rst_fill_v",     32'(fill_v), 32'h0);
        check("rst_cid_error",  32'(cid_error), 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // ch0 read 0x1000
        tx_exp_q.push_back(32'h0024_4134);
        tx_exp_q.push_back(32'h0000_1000);
        issue_req(0, 1'b0, 32'h1000);
        wait_done("ch0_read");
        check("ch0_read_yumi", 32'(pkt_yumi_cnt[0]), 32'd1);

        // ch1 write 0x2040, router ready toggling
        tx_toggle = 1;
        evict_total[1] = 8;
        tx_exp_q.push_back(32'h0025_5934);
        tx_exp_q.push_back(32'h0000_2040);
        for (int w = 0; w < 8; w++) tx_exp_q.push_back(32'hA0 + w);
        issue_req(1, 1'b1, 32'h2040);
        wait_done("ch1_write");
        tx_toggle = 0;
        check("ch1_write_pkt_yumi", 32'(pkt_yumi_cnt[1]), 32'd1);
        check("ch1_write_data_yumi", 32'(evict_yumi_cnt[1]), 32'd8);

        // simultaneous requests: grants must alternate 0,1 without interleaving
        for (int i = 0; i < 4; i++) begin
            tx_exp_q.push_back(32'h0024_4134);
            tx_exp_q.push_back(32'h3000 + 32'(i * 16));
            if (i == 0) begin
                evict_total[1] = evict_total[1] + 8;
                tx_exp_q.push_back(32'h0025_5934);
                tx_exp_q.push_back(32'h4000);
                for (int w = 0; w < 8; w++) tx_exp_q.push_back(32'hC0 + w);
                issue_req(0, 1'b0, 32'h3000);
                issue_req(1, 1'b1, 32'h4000);
            end else begin
                tx_exp_q.push_back(32'h0024_5134);
                tx_exp_q.push_back(32'h4000 + 32'(i * 16));
                issue_req(0, 1'b0, 32'h3000 + 32'(i * 16));
                issue_req(1, 1'b0, 32'h4000 + 32'(i * 16));
            end
            wait_done("rr_pair");
        end
        check("rr_pkt_yumi_ch0", 32'(pkt_yumi_cnt[0]), 32'd5);
        check("rr_pkt_yumi_ch1", 32'(pkt_yumi_cnt[1]), 32'd5);
        check("rr_evict_ch1",    32'(evict_yumi_cnt[1]), 32'd16);

        // response to ch1 with fill ready toggling
        fill_toggle = 1;
        for (int w = 0; w < 8; w++) fill_exp_q1.push_back(32'hB0 + w);
        rx_flit(32'h0000_5812);
        for (int w = 0; w < 8; w++) rx_flit(32'hB0 + w);
        wait_fill("resp_ch1");
        fill_toggle = 0;

        // len=0 header followed by a 2-beat response to ch0
        fill_exp_q0.push_back(32'hE0);
        fill_exp_q0.push_back(32'hE1);
        rx_flit(32'h0000_4012);
        rx_flit(32'h0000_4212);
        rx_flit(32'hE0);
        rx_flit(32'hE1);
        wait_fill("resp_len0");
        check("cid_error_clean", 32'(cid_error), 32'h0);

        // out-of-range channel: all flits consumed and dropped
        rx_flit(32'h0000_7812);
        for (int w = 0; w < 8; w++) rx_flit(32'hF0 + w);
        repeat (2) @(posedge clk);
        #1;
        check("cid_error_set", 32'(cid_error), 32'h1);

        // reset while the write waits on beat 3
        evict_total[0] = 3;
        tx_exp_q.push_back(32'h0025_4934);
        tx_exp_q.push_back(32'h0000_5000);
        for (int w = 0; w < 3; w++) tx_exp_q.push_back(32'hD0 + w);
        issue_req(0, 1'b1, 32'h5000);
        wait_done("ch0_partial_write");
        @(negedge clk);
        evict_total[0] = 4;
        @(posedge clk); #2;
        check("beat3_yumi_pre", 32'(evict_yumi[0]), 32'h1);
        reset_n = 1'b0;
        #1;
        check("abort_tx_v",       32'(tx_link.v), 32'h0);
        check("abort_evict_yumi", 32'(evict_yumi), 32'h0);
        check("abort_rx_ready",   32'(rx_link.ready_and), 32'h0);
        evict_total[0] = 3;
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("cid_error_cleared", 32'(cid_error), 32'h0);

        tx_exp_q.push_back(32'h0024_4134);
        tx_exp_q.push_back(32'h0000_6000);
        issue_req(0, 1'b0, 32'h6000);
        wait_done("ch0_read_after_reset");
        check("final_pkt_yumi_ch0", 32'(pkt_yumi_cnt[0]), 32'd7);
        check("final_tx_q_empty",   32'(tx_exp_q.size()), 32'd0);
        check("final_fill_q_empty", 32'(fill_exp_q0.size() + fill_exp_q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
